// File: rtl/data_sampling_unit_if.sv
// Signal bundle between the UART RX control side and the data sampling unit.
// The master drives the serial line, enable and prescale; the slave returns the voted bit and strobes.
interface data_sampling_unit_if #(
    parameter int PRESCALE_W = 6
);
    logic                  RX_IN;
    logic                  dat_samp_en;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  sampled_bit;
    logic                  sample_valid;
    logic                  bit_tick;
    logic                  cfg_err;

    modport master (
        output RX_IN,
        output dat_samp_en,
        output Prescale,
        input  sampled_bit,
        input  sample_valid,
        input  bit_tick,
        input  cfg_err
    );

    modport slave (
        input  RX_IN,
        input  dat_samp_en,
        input  Prescale,
        output sampled_bit,
        output sample_valid,
        output bit_tick,
        output cfg_err
    );
endinterface

// File: rtl/data_sampling_unit.sv
// UART RX oversampling front end: synchronises RX_IN, counts edges per bit period and
// registers a 3-sample majority vote around the bit centre.
module data_sampling_unit #(
    parameter int PRESCALE_W = 6
) (
    input  logic                 CLK,
    input  logic                 RST,
    data_sampling_unit_if.slave  dif
);

    localparam logic [PRESCALE_W-1:0] P8  = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] P16 = PRESCALE_W'(16);
    localparam logic [PRESCALE_W-1:0] P32 = PRESCALE_W'(32);
    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic                  sync_ff1_q, sync_ff1_d;
    logic                  sync_ff2_q, sync_ff2_d;
    logic [PRESCALE_W-1:0] p_lat_q, p_lat_d;
    logic                  cfg_err_q, cfg_err_d;
    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic                  s0_q, s0_d;
    logic                  s1_q, s1_d;
    logic                  sampled_bit_q, sampled_bit_d;
    logic                  sample_valid_q, sample_valid_d;
    logic                  bit_tick_q, bit_tick_d;

    logic [PRESCALE_W-1:0] prescale_in;
    logic                  prescale_legal;
    logic [PRESCALE_W-1:0] last_edge;
    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] half_m1;
    logic [PRESCALE_W-1:0] half_p1;
    logic                  rx_s;
    logic                  vote;

    assign prescale_in    = dif.Prescale;
    assign prescale_legal = (prescale_in == P8) || (prescale_in == P16) || (prescale_in == P32);
    assign last_edge      = p_lat_q - ONE;
    assign half           = p_lat_q >> 1;
    assign half_m1        = half - ONE;
    assign half_p1        = half + ONE;
    assign rx_s           = sync_ff2_q;
    assign vote           = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

    always_comb begin
        sync_ff1_d     = dif.RX_IN;
        sync_ff2_d     = sync_ff1_q;
        p_lat_d        = p_lat_q;
        cfg_err_d      = cfg_err_q;
        edge_cnt_d     = '0;
        s0_d           = s0_q;
        s1_d           = s1_q;
        sampled_bit_d  = sampled_bit_q;
        sample_valid_d = 1'b0;
        bit_tick_d     = 1'b0;

        if (!dif.dat_samp_en) begin
            // Ratio is only accepted between frames so a frame never sees a period change.
            p_lat_d   = prescale_legal ? prescale_in : P8;
            cfg_err_d = !prescale_legal;
        end else begin
            edge_cnt_d = (edge_cnt_q == last_edge) ? '0 : edge_cnt_q + ONE;
            bit_tick_d = (edge_cnt_q == last_edge);
            if (edge_cnt_q == half_m1) begin
                s0_d = rx_s;
            end
            if (edge_cnt_q == half) begin
                s1_d = rx_s;
            end
            // Third sample is taken live from the synchroniser and voted in the same cycle.
            if (edge_cnt_q == half_p1) begin
                sampled_bit_d  = vote;
                sample_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_ff1_q     <= 1'b1;
            sync_ff2_q     <= 1'b1;
            p_lat_q        <= P8;
            cfg_err_q      <= 1'b0;
            edge_cnt_q     <= '0;
            s0_q           <= 1'b0;
            s1_q           <= 1'b0;
            sampled_bit_q  <= 1'b1;
            sample_valid_q <= 1'b0;
            bit_tick_q     <= 1'b0;
        end else begin
            sync_ff1_q     <= sync_ff1_d;
            sync_ff2_q     <= sync_ff2_d;
            p_lat_q        <= p_lat_d;
            cfg_err_q      <= cfg_err_d;
            edge_cnt_q     <= edge_cnt_d;
            s0_q           <= s0_d;
            s1_q           <= s1_d;
            sampled_bit_q  <= sampled_bit_d;
            sample_valid_q <= sample_valid_d;
            bit_tick_q     <= bit_tick_d;
        end
    end

    assign dif.sampled_bit  = sampled_bit_q;
    assign dif.sample_valid = sample_valid_q;
    assign dif.bit_tick     = bit_tick_q;
    assign dif.cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_data_sampling_unit.sv
// Randomised plus directed bench for data_sampling_unit, checked every cycle against a
// frame-level model built from run position, modulo arithmetic and an input history.
module tb_data_sampling_unit;

    localparam int PW = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    data_sampling_unit_if #(.PRESCALE_W(PW)) dif ();

    data_sampling_unit #(.PRESCALE_W(PW)) dut (
        .CLK (clk),
        .RST (rst_n),
        .dif (dif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int run_idx;
    int p_lat;
    bit m_cfg, m_bit, m_valid, m_tick;
    bit hist[$];

    // Directed-scenario observations
    int cyc;
    bit valid_q[$];
    int valid_t[$];
    int tick_t[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        run_idx = 0;
        p_lat   = 8;
        m_cfg   = 1'b0;
        m_bit   = 1'b1;
        m_valid = 1'b0;
        m_tick  = 1'b0;
        hist    = '{1'b1, 1'b1, 1'b1, 1'b1};
    endfunction

    // One rising edge: en/rx/presc are the values present at that edge.
    function automatic void model_edge(input bit en, input bit rx, input int presc);
        int pos, h, sz, ones;
        hist.push_back(rx);
        if (hist.size() > 8) void'(hist.pop_front());
        m_valid = 1'b0;
        m_tick  = 1'b0;
        if (en) begin
            h   = p_lat / 2;
            pos = run_idx % p_lat;
            m_tick = (pos == p_lat - 1);
            if (pos == h + 1) begin
                // The line seen by the sampler lags the pin by two edges.
                sz   = hist.size();
                ones = int'(hist[sz-5]) + int'(hist[sz-4]) + int'(hist[sz-3]);
                m_bit   = (ones >= 2);
                m_valid = 1'b1;
            end
            run_idx++;
        end else begin
            run_idx = 0;
            if (presc == 8 || presc == 16 || presc == 32) begin
                p_lat = presc;
                m_cfg = 1'b0;
            end else begin
                p_lat = 8;
                m_cfg = 1'b1;
            end
        end
    endfunction

    task automatic check_outputs(input string ctx);
        check({ctx, "_sampled_bit"},  dif.sampled_bit,  m_bit);
        check({ctx, "_sample_valid"}, dif.sample_valid, m_valid);
        check({ctx, "_bit_tick"},     dif.bit_tick,     m_tick);
        check({ctx, "_cfg_err"},      dif.cfg_err,      m_cfg);
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge(dif.dat_samp_en, dif.RX_IN, int'(dif.Prescale));
        #1;
        check_outputs("cyc");
        cyc++;
        if (dif.sample_valid === 1'b1) begin
            valid_q.push_back(dif.sampled_bit);
            valid_t.push_back(cyc);
            $display("sample: bit=%0d step=%0d t=%0t", dif.sampled_bit, cyc, $time);
        end
        if (dif.bit_tick === 1'b1) tick_t.push_back(cyc);
    endtask

    task automatic clear_obs();
        cyc = 0;
        valid_q.delete();
        valid_t.delete();
        tick_t.delete();
    endtask

    // Asynchronous reset in the middle of a cycle, held for n edges.
    task automatic pulse_reset(input int n);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        for (int i = 0; i < n; i++) step();
        rst_n = 1'b1;
    endtask

    task automatic latch_prescale(input int p);
        dif.dat_samp_en = 1'b0;
        dif.Prescale    = PW'(p);
        step();
    endtask

    // P=16 run with rx forced to a,b,c at the three edges feeding the vote.
    task automatic vote_run(input bit base, input bit a, input bit b, input bit c, input bit exp, input string tag);
        latch_prescale(16);
        clear_obs();
        dif.dat_samp_en = 1'b1;
        for (int n = 0; n < 16; n++) begin
            dif.RX_IN = (n == 5) ? a : (n == 6) ? b : (n == 7) ? c : base;
            step();
        end
        check({tag, "_count"}, valid_q.size(), 1);
        if (valid_q.size() > 0) check({tag, "_value"}, valid_q[0], exp);
        dif.dat_samp_en = 1'b0;
        dif.RX_IN = 1'b1;
        step();
    endtask

    initial begin
        bit [9:0] frame;
        int       plist[6];
        plist = '{8, 16, 32, 12, 0, 40};

        rst_n = 1'b0;
        dif.RX_IN = 1'b1;
        dif.dat_samp_en = 1'b0;
        dif.Prescale = PW'(8);
        model_reset();
        clear_obs();

        // Reset held with a toggling line, then released while disabled.
        for (int i = 0; i < 6; i++) begin
            dif.RX_IN = i[0];
            step();
        end
        rst_n = 1'b1;
        dif.RX_IN = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Clean zero bit at P=8.
        latch_prescale(8);
        clear_obs();
        dif.dat_samp_en = 1'b1;
        dif.RX_IN = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("p8_valid_count", valid_q.size(), 1);
        if (valid_q.size() > 0) begin
            check("p8_valid_step", valid_t[0], 6);
            check("p8_valid_bit", valid_q[0], 0);
        end
        check("p8_tick_count", tick_t.size(), 1);
        if (tick_t.size() > 0) check("p8_tick_step", tick_t[0], 8);
        dif.dat_samp_en = 1'b0;
        dif.RX_IN = 1'b1;
        step();

        // Majority vote at P=16.
        vote_run(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "vote_101");
        vote_run(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "vote_010");
        vote_run(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "glitch_hi");
        vote_run(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "glitch_lo");

        // Full frame 0, 0xA5 LSB first, 1 at P=32.
        frame = {1'b1, 8'hA5, 1'b0};
        latch_prescale(32);
        clear_obs();
        dif.dat_samp_en = 1'b1;
        for (int n = 0; n < 322; n++) begin
            dif.RX_IN = frame[n / 32];
            step();
        end
        check("frame_valid_count", valid_q.size(), 10);
        check("frame_tick_count", tick_t.size(), 10);
        for (int i = 0; i < valid_q.size() && i < 10; i++) begin
            check($sformatf("frame_bit%0d", i), valid_q[i], frame[i]);
            if (i > 0) check($sformatf("frame_gap%0d", i), valid_t[i] - valid_t[i-1], 32);
        end
        if (valid_q.size() == 10) check("frame_stop_bit", valid_q[9], 1);
        dif.dat_samp_en = 1'b0;
        dif.RX_IN = 1'b1;
        step();

        // Illegal prescale falls back to 8.
        latch_prescale(12);
        step();
        check("illegal_cfg_err", dif.cfg_err, 1);
        clear_obs();
        dif.dat_samp_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            dif.RX_IN = 1'($urandom_range(0, 1));
            step();
        end
        check("illegal_tick_count", tick_t.size(), 2);
        if (tick_t.size() > 0) check("illegal_first_tick", tick_t[0], 8);

        // Prescale change mid-frame has no effect.
        latch_prescale(16);
        clear_obs();
        dif.dat_samp_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 5) dif.Prescale = PW'(8);
            step();
        end
        check("midframe_tick_count", tick_t.size(), 2);
        if (tick_t.size() > 1) check("midframe_tick_gap", tick_t[1] - tick_t[0], 16);
        dif.dat_samp_en = 1'b0;
        step();
        clear_obs();
        dif.dat_samp_en = 1'b1;
        for (int i = 0; i < 10; i++) step();
        if (tick_t.size() > 0) check("after_change_tick", tick_t[0], 8);
        else                   check("after_change_tick_count", tick_t.size(), 1);

        // Enable dropped at edge_cnt 3, then restart.
        latch_prescale(16);
        clear_obs();
        dif.dat_samp_en = 1'b1;
        for (int i = 0; i < 3; i++) step();
        dif.dat_samp_en = 1'b0;
        step();
        check("drop_no_valid", valid_q.size(), 0);
        check("drop_no_tick", tick_t.size(), 0);
        clear_obs();
        dif.dat_samp_en = 1'b1;
        for (int i = 0; i < 18; i++) step();
        if (tick_t.size() > 0) check("restart_tick", tick_t[0], 16);
        else                   check("restart_tick_count", tick_t.size(), 1);
        dif.dat_samp_en = 1'b0;
        step();

        // Reset mid-frame at edge_cnt 10; reset reloads P_lat=8 while still enabled.
        latch_prescale(16);
        dif.dat_samp_en = 1'b1;
        for (int i = 0; i < 10; i++) step();
        pulse_reset(2);
        clear_obs();
        for (int i = 0; i < 12; i++) step();
        if (tick_t.size() > 0) check("post_reset_tick", tick_t[0], 8);
        else                   check("post_reset_tick_count", tick_t.size(), 1);
        dif.dat_samp_en = 1'b0;
        step();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) dif.dat_samp_en = ~dif.dat_samp_en;
            if ($urandom_range(0, 19) == 0) dif.Prescale = PW'(plist[$urandom_range(0, 5)]);
            if ($urandom_range(0, 5) == 0)  dif.RX_IN = ~dif.RX_IN;
            if ($urandom_range(0, 499) == 0) pulse_reset(1);
            else step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
